// File: rtl/nios_data_out_i2c_pkg.sv
// Register map and bit positions shared by the NIOS-to-I2C byte output block.
package nios_data_out_i2c_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_STATUS  = 2'd1,
    ADDR_CONTROL = 2'd2,
    ADDR_IRQMASK = 2'd3
  } reg_addr_e;

  localparam int BUS_W        = 32;
  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 8;
  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;

endpackage

// File: rtl/nios_data_out_i2c_if.sv
// Avalon-MM slave bus plus the valid/ready byte stream toward the I2C transmitter.
interface nios_data_out_i2c_if #(
  parameter int DATA_WIDTH = 8
);
  logic [1:0]            address;
  logic                  chipselect;
  logic                  write_n;
  logic [31:0]           writedata;
  logic [31:0]           readdata;
  logic [DATA_WIDTH-1:0] out_port;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output address, chipselect, write_n, writedata, out_ready,
    input  readdata, out_port, out_valid
  );

  modport slave (
    input  address, chipselect, write_n, writedata, out_ready,
    output readdata, out_port, out_valid
  );
endinterface

// File: rtl/nios_data_out_i2c_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted only when a pop
// frees the head slot in the same cycle.
module nios_data_out_i2c_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok && !flush && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nios_data_out_i2c.sv
// NIOS byte output path to the I2C transmitter: Avalon decode, registered read mux,
// sticky overflow; optional irq when NIOS_DATA_OUT_I2C_IRQ_EN is defined.
module nios_data_out_i2c
  import nios_data_out_i2c_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  nios_data_out_i2c_if.slave  bus
`ifdef NIOS_DATA_OUT_I2C_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  reg_addr_e             addr;
  logic                  wr;
  logic                  pop;
  logic                  push;
  logic                  flush;
  logic                  clr_ovf;
  logic                  drop;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] head;
  logic [BUS_W-1:0]      status;
  logic [BUS_W-1:0]      rd_mux;
  logic                  unused_wdata;

  assign addr    = reg_addr_e'(bus.address);
  assign wr      = bus.chipselect & ~bus.write_n;
  assign pop     = bus.out_valid & bus.out_ready;
  assign push    = wr & (addr == ADDR_DATA);
  assign flush   = wr & (addr == ADDR_CONTROL) & bus.writedata[CTRL_FLUSH];
  assign clr_ovf = wr & (addr == ADDR_CONTROL) & bus.writedata[CTRL_CLR_OVF];
  assign drop    = push & full & ~pop;

  assign unused_wdata = ^bus.writedata;

  nios_data_out_i2c_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (bus.writedata[DATA_WIDTH-1:0]),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign bus.out_valid = ~empty;
  assign bus.out_port  = head;

  // A dropped byte and a clear in the same cycle leave the flag set.
  always_ff @(posedge clk) begin
    if (reset)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  always_comb begin
    status                          = '0;
    status[STAT_EMPTY]              = empty;
    status[STAT_FULL]               = full;
    status[STAT_OVF]                = overflow;
    status[STAT_CNT_LSB +: CNT_W]   = count;
  end

`ifdef NIOS_DATA_OUT_I2C_IRQ_EN
  logic [1:0] mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr && addr == ADDR_IRQMASK) mask <= bus.writedata[1:0];
      irq <= (mask[0] & empty) | (mask[1] & overflow);
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_DATA:    rd_mux = BUS_W'(head);
      ADDR_STATUS:  rd_mux = status;
`ifdef NIOS_DATA_OUT_I2C_IRQ_EN
      ADDR_IRQMASK: rd_mux = BUS_W'(mask);
`endif
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) bus.readdata <= '0;
    else       bus.readdata <= rd_mux;
  end

endmodule

// File: tb/tb_nios_data_out_i2c.sv
// Bench for nios_data_out_i2c: directed scenarios plus random traffic against a
// queue-based reference model; define NIOS_DATA_OUT_I2C_IRQ_EN to cover the irq build.
module tb_nios_data_out_i2c;
  import nios_data_out_i2c_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nios_data_out_i2c_if #(.DATA_WIDTH(DW)) bus ();
`ifdef NIOS_DATA_OUT_I2C_IRQ_EN
  logic irq;
`endif

  nios_data_out_i2c #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef NIOS_DATA_OUT_I2C_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  logic [7:0]  q[$];
  bit          ovf_m;
  logic [1:0]  mask_m;
  logic [31:0] exp_rd;
  bit          exp_irq;
  int          errors = 0;
  int          checks = 0;

  // Advance one edge, updating the model from the inputs present before the edge.
  task automatic tick();
    int          n;
    bit          wr, pop, push, flush, clr, set;
    logic [31:0] rd_next;
    bit          irq_next;
    n = q.size();
    wr = bus.chipselect && !bus.write_n;
    pop = bus.out_ready && (n > 0);
    rd_next = 32'h0;
    case (bus.address)
      2'd0: rd_next = (n > 0) ? 32'(q[0]) : 32'h0;
      2'd1: begin
        rd_next = 32'(n) << 8;
        rd_next[0] = (n == 0);
        rd_next[1] = (n == DEPTH);
        rd_next[2] = ovf_m;
      end
`ifdef NIOS_DATA_OUT_I2C_IRQ_EN
      2'd3: rd_next = 32'(mask_m);
`endif
      default: rd_next = 32'h0;
    endcase
    irq_next = (mask_m[0] && n == 0) || (mask_m[1] && ovf_m);
    push  = wr && bus.address == 2'd0 && (n < DEPTH || pop);
    set   = wr && bus.address == 2'd0 && !push;
    flush = wr && bus.address == 2'd2 && bus.writedata[0];
    clr   = wr && bus.address == 2'd2 && bus.writedata[1];
    if (reset) begin
      q.delete();
      ovf_m = 1'b0;
      mask_m = 2'b00;
      rd_next = 32'h0;
      irq_next = 1'b0;
    end else begin
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(bus.writedata[7:0]);
      end
      if (set) ovf_m = 1'b1;
      else if (clr) ovf_m = 1'b0;
`ifdef NIOS_DATA_OUT_I2C_IRQ_EN
      if (wr && bus.address == 2'd3) mask_m = bus.writedata[1:0];
`endif
    end
    @(posedge clk);
    #1;
    exp_rd = rd_next;
    exp_irq = irq_next;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    bus.address = a;
    bus.writedata = d;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.address = 2'd1;
    bus.writedata = 32'h0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 00000000", bus.readdata); end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.readdata !== 32'h1) begin errors++; $display("FAIL reset_status: got %h expected 00000001", bus.readdata); end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_port !== 8'h0) begin errors++; $display("FAIL reset_out: got valid=%b port=%h expected 0/00", bus.out_valid, bus.out_port); end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b0;
    wr_reg(ADDR_DATA, 32'hFFFF_FFA5);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_port !== 8'hA5) begin errors++; $display("FAIL single_push: got valid=%b port=%h expected 1/a5", bus.out_valid, bus.out_port); end
    bus.address = ADDR_STATUS;
    tick();
    checks++;
    if (bus.readdata !== 32'h0000_0100) begin errors++; $display("FAIL single_status: got %h expected 00000100", bus.readdata); end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got valid=%b expected 0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) wr_reg(ADDR_DATA, 32'(i));
    bus.address = ADDR_STATUS;
    tick();
    checks++;
    if (bus.readdata !== 32'h0000_0802) begin errors++; $display("FAIL fill_full: got %h expected 00000802", bus.readdata); end
    wr_reg(ADDR_DATA, 32'h09);
    bus.address = ADDR_STATUS;
    tick();
    checks++;
    if (bus.readdata !== 32'h0000_0806) begin errors++; $display("FAIL fill_overflow: got %h expected 00000806", bus.readdata); end
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_port !== 8'(i)) begin errors++; $display("FAIL drain_order: got valid=%b port=%h expected 1/%h", bus.out_valid, bus.out_port, 8'(i)); end
      tick();
    end
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got valid=%b expected 0", bus.out_valid); end
    wr_reg(ADDR_CONTROL, 32'h2);
    bus.address = ADDR_STATUS;
    tick();
    checks++;
    if (bus.readdata !== 32'h1) begin errors++; $display("FAIL clr_ovf: got %h expected 00000001", bus.readdata); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] expv [9];
    for (int i = 0; i < 8; i++) wr_reg(ADDR_DATA, 32'(8'h11 + 8'(i)));
    bus.out_ready = 1'b1;
    wr_reg(ADDR_DATA, 32'h55);
    bus.out_ready = 1'b0;
    bus.address = ADDR_STATUS;
    tick();
    checks++;
    if (bus.readdata !== 32'h0000_0802) begin errors++; $display("FAIL fullpp_status: got %h expected 00000802", bus.readdata); end
    for (int i = 0; i < 7; i++) expv[i] = 8'h12 + 8'(i);
    expv[7] = 8'h55;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_port !== expv[i]) begin errors++; $display("FAIL fullpp_drain: got valid=%b port=%h expected 1/%h", bus.out_valid, bus.out_port, expv[i]); end
      tick();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) wr_reg(ADDR_DATA, 32'(8'hC0 + 8'(i)));
    wr_reg(ADDR_CONTROL, 32'h3);
    bus.address = ADDR_STATUS;
    tick();
    checks++;
    if (bus.readdata !== 32'h1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush: got status=%h valid=%b expected 00000001/0", bus.readdata, bus.out_valid); end
    wr_reg(ADDR_DATA, 32'h3C);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_port !== 8'h3C) begin errors++; $display("FAIL flush_repush: got valid=%b port=%h expected 1/3c", bus.out_valid, bus.out_port); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    wr_reg(ADDR_DATA, 32'h81);
    wr_reg(ADDR_DATA, 32'h82);
    bus.out_ready = 1'b1;
    reset = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_port !== 8'h0) begin errors++; $display("FAIL reset_mid: got valid=%b port=%h expected 0/00", bus.out_valid, bus.out_port); end
    reset = 1'b0;
    bus.out_ready = 1'b0;
    tick();
  endtask

  task automatic test_irqmask();
`ifdef NIOS_DATA_OUT_I2C_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_reset: got %b expected 0", irq); end
    wr_reg(ADDR_IRQMASK, 32'h1);
    bus.address = ADDR_IRQMASK;
    tick();
    checks++;
    if (irq !== 1'b1 || bus.readdata !== 32'h1) begin errors++; $display("FAIL irq_empty: got irq=%b mask=%h expected 1/00000001", irq, bus.readdata); end
    wr_reg(ADDR_DATA, 32'h77);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_lag: got %b expected 1", irq); end
    tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
    wr_reg(ADDR_IRQMASK, 32'h0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
`else
    wr_reg(ADDR_IRQMASK, 32'hFFFF_FFFF);
    bus.address = ADDR_IRQMASK;
    tick();
    checks++;
    if (bus.readdata !== 32'h0) begin errors++; $display("FAIL addr3_reads0: got %h expected 00000000", bus.readdata); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.out_ready = ($urandom_range(0, 3) < ((i < 300) ? 1 : 3));
      bus.writedata = $urandom();
      bus.address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        bus.chipselect = 1'b1;
        bus.write_n = 1'b0;
        case ($urandom_range(0, 9))
          0:       bus.address = ADDR_CONTROL;
          1:       bus.address = ADDR_IRQMASK;
          default: bus.address = ADDR_DATA;
        endcase
      end else begin
        bus.chipselect = 1'($urandom_range(0, 1));
        bus.write_n = 1'b1;
      end
      tick();
      checks++;
      if (bus.out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid: cycle %0d got %b expected %b", i, bus.out_valid, q.size() != 0); end
      checks++;
      if (bus.out_port !== ((q.size() != 0) ? q[0] : 8'h0)) begin errors++; $display("FAIL rnd_port: cycle %0d got %h expected %h", i, bus.out_port, (q.size() != 0) ? q[0] : 8'h0); end
      checks++;
      if (bus.readdata !== exp_rd) begin errors++; $display("FAIL rnd_readdata: cycle %0d got %h expected %h", i, bus.readdata, exp_rd); end
`ifdef NIOS_DATA_OUT_I2C_IRQ_EN
      checks++;
      if (irq !== exp_irq) begin errors++; $display("FAIL rnd_irq: cycle %0d got %b expected %b", i, irq, exp_irq); end
`endif
    end
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_flush();
    test_reset_mid();
    test_irqmask();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
